// File: rtl/logit9slices.sv
// logit9slices: two-lane inverse-sigmoid (logit) evaluator.
// Maps Q5.11 probabilities to Q5.11 pre-activations in [-6, 6] using a
// 9-segment piecewise-linear table. The knots are the images of the forward
// 9-slice sigmoid breakpoints. A three-stage pipeline handles valid/ready
// backpressure, and the whole pipe freezes while the output is stalled.
// Build option: define LOGIT_ROUND_EN to round the S2 shift to nearest
// (+128 before >> 8). Without it, the shift truncates toward -inf.

module logit9slices (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] y0_in,
    input  logic [15:0] y1_in,
    input  logic        valid_in,
    output logic        ready_in,
    output logic [15:0] x0_out,
    output logic [15:0] x1_out,
    output logic        valid_out,
    input  logic        ready_out
);

    // Saturation thresholds and the output clamp range.
    localparam logic signed [15:0] Y_SAT_LO = 16'sd5;
    localparam logic signed [15:0] Y_SAT_HI = 16'sd2043;
    localparam logic signed [28:0] X_MIN    = -29'sd12288;
    localparam logic signed [28:0] X_MAX    = 29'sd12288;

    // Lower knot of segment k (y-codes). Only segments 0..8 exist.
    function automatic logic [10:0] knotY(input logic [3:0] k);
        logic [10:0] v;
        case (k)
            4'd0:    v = 11'd5;
            4'd1:    v = 11'd19;
            4'd2:    v = 11'd70;
            4'd3:    v = 11'd244;
            4'd4:    v = 11'd695;
            4'd5:    v = 11'd1353;
            4'd6:    v = 11'd1804;
            4'd7:    v = 11'd1978;
            4'd8:    v = 11'd2029;
            default: v = 11'd0;
        endcase
        return v;
    endfunction

    // Logit value at the lower knot of segment k (x-codes).
    function automatic logic signed [15:0] knotX(input logic [3:0] k);
        logic signed [15:0] v;
        case (k)
            4'd0:    v = -16'sd12288;
            4'd1:    v = -16'sd9557;
            4'd2:    v = -16'sd6827;
            4'd3:    v = -16'sd4096;
            4'd4:    v = -16'sd1365;
            4'd5:    v = 16'sd1365;
            4'd6:    v = 16'sd4096;
            4'd7:    v = 16'sd6827;
            4'd8:    v = 16'sd9557;
            default: v = 16'sd0;
        endcase
        return v;
    endfunction

    // Segment slope, unsigned Q8.8 x-codes per y-code.
    function automatic logic [15:0] slopeM(input logic [3:0] k);
        logic [15:0] v;
        case (k)
            4'd0:    v = 16'd49938;
            4'd1:    v = 16'd13704;
            4'd2:    v = 16'd4018;
            4'd3:    v = 16'd1550;
            4'd4:    v = 16'd1062;
            4'd5:    v = 16'd1550;
            4'd6:    v = 16'd4018;
            4'd7:    v = 16'd13704;
            4'd8:    v = 16'd49938;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    // A y equal to a knot falls into the segment above it. The result is only
    // used when y lies strictly inside the unsaturated band.
    function automatic logic [3:0] segOf(input logic signed [15:0] y);
        logic [3:0] k;
        if (y < 16'sd19)        k = 4'd0;
        else if (y < 16'sd70)   k = 4'd1;
        else if (y < 16'sd244)  k = 4'd2;
        else if (y < 16'sd695)  k = 4'd3;
        else if (y < 16'sd1353) k = 4'd4;
        else if (y < 16'sd1804) k = 4'd5;
        else if (y < 16'sd1978) k = 4'd6;
        else if (y < 16'sd2029) k = 4'd7;
        else                    k = 4'd8;
        return k;
    endfunction

    // Final output selection. Saturation wins over the clamped segment sum.
    function automatic logic [15:0] clampOut(input logic satLo, input logic satHi,
                                             input logic signed [28:0] sum);
        logic [15:0] v;
        if (satLo)            v = 16'(X_MIN);
        else if (satHi)       v = 16'(X_MAX);
        else if (sum < X_MIN) v = 16'(X_MIN);
        else if (sum > X_MAX) v = 16'(X_MAX);
        else                  v = sum[15:0];
        return v;
    endfunction

    logic w_stall;

    logic w_satLo0, w_satHi0, w_satLo1, w_satHi1;
    logic [3:0]  w_seg0, w_seg1;
    logic [10:0] w_dy0, w_dy1;

    logic               r_s1Valid;
    logic               r_s1SatLo0, r_s1SatHi0, r_s1SatLo1, r_s1SatHi1;
    logic [10:0]        r_s1Dy0, r_s1Dy1;
    logic [15:0]        r_s1M0, r_s1M1;
    logic signed [15:0] r_s1X0, r_s1X1;

    logic [27:0]        w_prod0, w_prod1;
    logic [27:0]        w_prodRnd0, w_prodRnd1;
    logic signed [28:0] w_shifted0, w_shifted1;
    logic signed [28:0] w_sum0, w_sum1;

    logic               r_s2Valid;
    logic               r_s2SatLo0, r_s2SatHi0, r_s2SatLo1, r_s2SatHi1;
    logic signed [28:0] r_s2Sum0, r_s2Sum1;

    logic [15:0] r_x0Out, r_x1Out;
    logic        r_outValid;

    // A valid output that downstream refuses freezes every stage. Reset also
    // forces ready so upstream never sees a stall while the pipe is cleared.
    assign w_stall  = r_outValid && !ready_out;
    assign ready_in = !w_stall || !rst_n;

    // S1 combinational decode: saturation flags, segment and offset per lane.
    always_comb begin
        w_satLo0 = $signed(y0_in) <= Y_SAT_LO;
        w_satHi0 = $signed(y0_in) >= Y_SAT_HI;
        w_seg0   = segOf($signed(y0_in));
        w_dy0    = y0_in[10:0] - knotY(w_seg0);
        w_satLo1 = $signed(y1_in) <= Y_SAT_LO;
        w_satHi1 = $signed(y1_in) >= Y_SAT_HI;
        w_seg1   = segOf($signed(y1_in));
        w_dy1    = y1_in[10:0] - knotY(w_seg1);
    end

    // S1 registers: capture the decoded segment parameters of an accepted pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid  <= 1'b0;
            r_s1SatLo0 <= 1'b0;
            r_s1SatHi0 <= 1'b0;
            r_s1SatLo1 <= 1'b0;
            r_s1SatHi1 <= 1'b0;
            r_s1Dy0    <= '0;
            r_s1Dy1    <= '0;
            r_s1M0     <= '0;
            r_s1M1     <= '0;
            r_s1X0     <= '0;
            r_s1X1     <= '0;
        end else if (!w_stall) begin
            r_s1Valid  <= valid_in;
            r_s1SatLo0 <= w_satLo0;
            r_s1SatHi0 <= w_satHi0;
            r_s1SatLo1 <= w_satLo1;
            r_s1SatHi1 <= w_satHi1;
            r_s1Dy0    <= w_dy0;
            r_s1Dy1    <= w_dy1;
            r_s1M0     <= slopeM(w_seg0);
            r_s1M1     <= slopeM(w_seg1);
            r_s1X0     <= knotX(w_seg0);
            r_s1X1     <= knotX(w_seg1);
        end
    end

    // S2 datapath: slope times offset, scaled back from Q8.8, plus the knot value.
    always_comb begin
        w_prod0 = 28'(r_s1M0) * 28'(r_s1Dy0);
        w_prod1 = 28'(r_s1M1) * 28'(r_s1Dy1);
`ifdef LOGIT_ROUND_EN
        w_prodRnd0 = w_prod0 + 28'd128;
        w_prodRnd1 = w_prod1 + 28'd128;
`else
        w_prodRnd0 = w_prod0;
        w_prodRnd1 = w_prod1;
`endif
        w_shifted0 = $signed({1'b0, w_prodRnd0}) >>> 8;
        w_shifted1 = $signed({1'b0, w_prodRnd1}) >>> 8;
        w_sum0     = 29'(r_s1X0) + w_shifted0;
        w_sum1     = 29'(r_s1X1) + w_shifted1;
    end

    // S2 registers: hold the unclamped sums and forward the saturation flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2Valid  <= 1'b0;
            r_s2SatLo0 <= 1'b0;
            r_s2SatHi0 <= 1'b0;
            r_s2SatLo1 <= 1'b0;
            r_s2SatHi1 <= 1'b0;
            r_s2Sum0   <= '0;
            r_s2Sum1   <= '0;
        end else if (!w_stall) begin
            r_s2Valid  <= r_s1Valid;
            r_s2SatLo0 <= r_s1SatLo0;
            r_s2SatHi0 <= r_s1SatHi0;
            r_s2SatLo1 <= r_s1SatLo1;
            r_s2SatHi1 <= r_s1SatHi1;
            r_s2Sum0   <= w_sum0;
            r_s2Sum1   <= w_sum1;
        end
    end

    // S3 output registers: clamp or saturate, then hold while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_x0Out    <= '0;
            r_x1Out    <= '0;
        end else if (!w_stall) begin
            r_outValid <= r_s2Valid;
            r_x0Out    <= clampOut(r_s2SatLo0, r_s2SatHi0, r_s2Sum0);
            r_x1Out    <= clampOut(r_s2SatLo1, r_s2SatHi1, r_s2Sum1);
        end
    end

    assign x0_out    = r_x0Out;
    assign x1_out    = r_x1Out;
    assign valid_out = r_outValid;

endmodule

// File: tb/tb_logit9slices.sv
// tb_logit9slices: directed and randomized checks of logit9slices against
// a table-and-arithmetic reference model and a three-slot latency model.

module tb_logit9slices;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] y0_in, y1_in;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] x0_out, x1_out;
    logic        valid_out;
    logic        ready_out;

    int nVec = 0;
    int nMis = 0;

    int kY [10] = '{5, 19, 70, 244, 695, 1353, 1804, 1978, 2029, 2043};
    int kX [10] = '{-12288, -9557, -6827, -4096, -1365, 1365, 4096, 6827, 9557, 12288};
    int kM [9]  = '{49938, 13704, 4018, 1550, 1062, 1550, 4018, 13704, 49938};

    // Expected contents of the three pipeline positions; slot 2 is the output.
    logic        mV  [3];
    logic [15:0] mX0 [3];
    logic [15:0] mX1 [3];
    bit          rstChk;

    logit9slices dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .y0_in     (y0_in),
        .y1_in     (y1_in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .x0_out    (x0_out),
        .x1_out    (x1_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Reference logit computed directly from the knot and slope tables.
    function automatic int refLogit(input int y);
        int p;
        int r;
        if (y <= 5)    return -12288;
        if (y >= 2043) return 12288;
        r = 0;
        for (int k = 0; k < 9; k++) begin
            if (y >= kY[k] && y < kY[k+1]) begin
                p = kM[k] * (y - kY[k]);
`ifdef LOGIT_ROUND_EN
                p = p + 128;
`endif
                r = kX[k] + p / 256;
            end
        end
        if (r < -12288) r = -12288;
        if (r > 12288)  r = 12288;
        return r;
    endfunction

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic checkOutput();
        logic expReady;
        expReady = !(mV[2] && !ready_out) || !rst_n;
        check16("valid_out", {15'd0, valid_out}, {15'd0, mV[2]});
        check16("ready_in", {15'd0, ready_in}, {15'd0, expReady});
        if (mV[2] || rstChk) begin
            check16("x0_out", x0_out, mX0[2]);
            check16("x1_out", x1_out, mX1[2]);
        end
    endtask

    task automatic applyStimulus(input logic v, input int y0, input int y1,
                                 input logic rdy, input logic rst);
        logic stall;
        valid_in  = v;
        y0_in     = 16'(y0);
        y1_in     = 16'(y1);
        ready_out = rdy;
        rst_n     = !rst;
        stall     = mV[2] && !rdy;
        @(posedge clk);
        if (rst) begin
            rstChk = 1'b1;
            for (int i = 0; i < 3; i++) begin
                mV[i]  = 1'b0;
                mX0[i] = 16'd0;
                mX1[i] = 16'd0;
            end
        end else begin
            rstChk = 1'b0;
            if (!stall) begin
                for (int i = 2; i > 0; i--) begin
                    mV[i]  = mV[i-1];
                    mX0[i] = mX0[i-1];
                    mX1[i] = mX1[i-1];
                end
                mV[0]  = v;
                mX0[0] = 16'(refLogit(y0));
                mX1[0] = 16'(refLogit(y1));
            end
        end
        #1;
        checkOutput();
    endtask

    initial begin
        int y0;
        int y1;
        for (int i = 0; i < 3; i++) begin
            mV[i]  = 1'b0;
            mX0[i] = 16'd0;
            mX1[i] = 16'd0;
        end
        rstChk    = 1'b0;
        rst_n     = 1'b0;
        valid_in  = 1'b0;
        y0_in     = '0;
        y1_in     = '0;
        ready_out = 1'b1;

        // Reset.
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);

        // Saturation, knots and the centre value, followed by bubbles to observe latency.
        applyStimulus(1'b1, 5, 2043, 1'b1, 1'b0);
        applyStimulus(1'b1, -3, 3000, 1'b1, 1'b0);
        applyStimulus(1'b1, 244, 1804, 1'b1, 1'b0);
        applyStimulus(1'b1, 1024, 1024, 1'b1, 1'b0);
        applyStimulus(1'b1, 6, 2042, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

        // Back-to-back sweep across the full probability range.
        for (int i = 0; i < 20; i++) begin
            y0 = i * 2048 / 19;
            applyStimulus(1'b1, y0, 2048 - y0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

        // Backpressure: three pairs, then four cycles of refused output.
        applyStimulus(1'b1, 100, 1500, 1'b1, 1'b0);
        applyStimulus(1'b1, 700, 1900, 1'b1, 1'b0);
        applyStimulus(1'b1, 1200, 30, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 400, 400, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

        // Randomized traffic with random gaps, backpressure and knot-adjacent values.
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                y0 = int'($urandom_range(0, 2400)) - 100;
                y1 = int'($urandom_range(0, 2400)) - 100;
            end else begin
                y0 = kY[$urandom_range(0, 9)] + int'($urandom_range(0, 2)) - 1;
                y1 = kY[$urandom_range(0, 9)] + int'($urandom_range(0, 2)) - 1;
            end
            applyStimulus($urandom_range(0, 3) != 0, y0, y1, $urandom_range(0, 3) != 0, 1'b0);
        end
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

        // Reset with two pairs in flight; nothing stale may emerge afterwards.
        applyStimulus(1'b1, 300, 1700, 1'b1, 1'b0);
        applyStimulus(1'b1, 900, 1100, 1'b1, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 0, 0, 1'b1, 1'b0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
